// File: rtl/shadow_round_ctrl_pkg.sv
// shadow_round_ctrl_pkg: shared state encoding, default sizing and counter width helper
package shadow_round_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN_A, RUN_B, DONE} state_t;
  localparam int NSTEPS_DEF = 6;
  localparam int PHASE_CYC_DEF = 4;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/shadow_phase_cnt.sv
// shadow_phase_cnt: cycle-in-phase and step counters with wrap and last-step flags
module shadow_phase_cnt import shadow_round_ctrl_pkg::*; #(
  parameter int NSTEPS = NSTEPS_DEF,
  parameter int PHASE_CYC = PHASE_CYC_DEF,
  localparam int SW = cnt_w(NSTEPS),
  localparam int CW = cnt_w(PHASE_CYC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          inc_step,
  output logic [CW-1:0] cyc,
  output logic [SW-1:0] step,
  output logic          wrap,
  output logic          last
);
  assign wrap = cyc == CW'(PHASE_CYC - 1);
  assign last = step == SW'(NSTEPS - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cyc <= '0;
      step <= '0;
    end else begin
      cyc <= clr || (inc && wrap) ? '0 : cyc + CW'(inc);
      step <= clr ? '0 : step + SW'(inc_step);
    end
endmodule

// File: rtl/shadow_round_ctrl.sv
// shadow_round_ctrl: sequences one Shadow-512 call through LOAD, NSTEPS x (phase A, phase B), DONE
module shadow_round_ctrl import shadow_round_ctrl_pkg::*; #(
  parameter int NSTEPS = NSTEPS_DEF,
  parameter int PHASE_CYC = PHASE_CYC_DEF,
  localparam int SW = cnt_w(NSTEPS),
  localparam int CW = cnt_w(PHASE_CYC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          rnd_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          ld_state,
  output logic          en_phase_a,
  output logic          en_phase_b,
  output logic          rnd_ready,
  output logic [SW-1:0] step,
  output logic [CW-1:0] cyc,
  output logic          lfsr_n_syn_rst,
  output logic          lfsr_enable,
  output logic          out_valid
);
  state_t st, nxt;
  logic clr, inc, inc_step, wrap, last, n_rst;
  shadow_phase_cnt #(.NSTEPS(NSTEPS), .PHASE_CYC(PHASE_CYC)) u_cnt (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc), .inc_step(inc_step),
    .cyc(cyc), .step(step), .wrap(wrap), .last(last)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= nxt;
  assign busy = st != IDLE;
  // the LFSR must also sit at its init value while the async reset is held
  assign lfsr_n_syn_rst = n_rst && !rst;
  always_comb begin
    nxt = st;
    clr = 1'b0;
    inc = 1'b0;
    inc_step = 1'b0;
    ld_state = 1'b0;
    en_phase_a = 1'b0;
    en_phase_b = 1'b0;
    rnd_ready = 1'b0;
    lfsr_enable = 1'b0;
    out_valid = 1'b0;
    n_rst = 1'b1;
    case (st)
      IDLE: nxt = start ? LOAD : IDLE;
      LOAD: begin
        ld_state = 1'b1;
        n_rst = 1'b0;
        clr = 1'b1;
        nxt = RUN_A;
      end
      RUN_A: begin
        en_phase_a = rnd_valid;
        rnd_ready = rnd_valid;
        inc = rnd_valid;
        nxt = rnd_valid && wrap ? RUN_B : RUN_A;
      end
      RUN_B: begin
        en_phase_b = rnd_valid;
        rnd_ready = rnd_valid;
        inc = rnd_valid;
        lfsr_enable = rnd_valid && wrap;
        inc_step = rnd_valid && wrap && !last;
        nxt = !(rnd_valid && wrap) ? RUN_B : last ? DONE : RUN_A;
      end
      DONE: begin
        out_valid = 1'b1;
        clr = out_ready;
        nxt = !out_ready ? DONE : start ? LOAD : IDLE;
      end
      default: nxt = IDLE;
    endcase
    if (abort) begin
      nxt = IDLE;
      clr = 1'b1;
      inc = 1'b0;
      inc_step = 1'b0;
      ld_state = 1'b0;
      en_phase_a = 1'b0;
      en_phase_b = 1'b0;
      rnd_ready = 1'b0;
      lfsr_enable = 1'b0;
      out_valid = 1'b0;
      n_rst = 1'b0;
    end
  end
endmodule
